// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths and types for the register-bank write side.
package riscv_pkg;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   val;
    } wb_entry_t;

    typedef enum logic [1:0] {SEL_NONE, SEL_LD, SEL_Q, SEL_ALU} wb_sel_e;

    function automatic wb_entry_t mk_entry(input logic [REG_AW-1:0] rd, input logic [XLEN-1:0] val);
        return '{rd: rd, val: val};
    endfunction
endpackage

// File: rtl/writeback_unit_fifo.sv
// wb_fifo: DEPTH-entry FIFO of writeback entries; exports per-slot rd/valid
// so the hazard check can see every result still waiting to retire.
module wb_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  wb_entry_t                    push_data_i,
    input  logic                         pop_i,
    output wb_entry_t                    head_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [DEPTH-1:0]             ent_vld_o,
    output logic [DEPTH-1:0][REG_AW-1:0] ent_rd_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_q, rd_q, cnt;
    wb_entry_t   mem_q [DEPTH];

    // extra pointer bit distinguishes full from empty when the slot bits match
    assign cnt     = wr_q - rd_q;
    assign empty_o = wr_q == rd_q;
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign head_o  = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + (AW+1)'(1);
            if (pop_i)  rd_q <= rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q[AW-1:0]] <= push_data_i;
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic [AW-1:0] off;
        assign off          = AW'(i) - rd_q[AW-1:0];
        assign ent_vld_o[i] = {1'b0, off} < cnt;
        assign ent_rd_o[i]  = mem_q[i].rd;
    end
endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: arbitrates ALU and load results onto the single register-bank
// write port and tracks registers with outstanding loads for decode stalls.
module writeback_unit
    import riscv_pkg::*;
#(
    parameter int NREG   = 32,
    parameter int QDEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_val,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [REG_AW-1:0] ld_rd,
    input  logic [XLEN-1:0]   ld_val,
    input  logic              issue_ld,
    input  logic [REG_AW-1:0] issue_rd,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    output logic              stall,
    output logic              reg_we,
    output logic [REG_AW-1:0] rd,
    output logic [XLEN-1:0]   rd_val
);
    wb_sel_e                      sel;
    wb_entry_t                    q_head, pick, wb_q, wb_d;
    logic                         q_full, q_empty, push, pop, ld_acc;
    logic                         we_q, we_d;
    logic [QDEPTH-1:0]            ent_vld;
    logic [QDEPTH-1:0][REG_AW-1:0] ent_rd;
    logic [NREG-1:0]              busy_q, busy_d;
    logic [1:0][REG_AW-1:0]       src;
    logic [1:0]                   hit;

    assign alu_ready = rst_n && !q_full;
    assign ld_ready  = rst_n && !q_full;

    // a full queue must drain first so the ALU path can never deadlock behind loads
    assign sel = q_full    ? SEL_Q   :
                 ld_valid  ? SEL_LD  :
                 !q_empty  ? SEL_Q   :
                 alu_valid ? SEL_ALU : SEL_NONE;

    assign pick = sel == SEL_LD  ? mk_entry(ld_rd, ld_val)   :
                  sel == SEL_Q   ? q_head                    :
                  sel == SEL_ALU ? mk_entry(alu_rd, alu_val) : wb_entry_t'('0);

    assign ld_acc = sel == SEL_LD;
    assign pop    = sel == SEL_Q;
    assign push   = alu_valid && alu_ready && sel != SEL_ALU;
    assign wb_d   = pick;
    assign we_d   = sel != SEL_NONE && pick.rd != '0;

    wb_fifo #(.DEPTH(QDEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push),
        .push_data_i(mk_entry(alu_rd, alu_val)),
        .pop_i      (pop),
        .head_o     (q_head),
        .full_o     (q_full),
        .empty_o    (q_empty),
        .ent_vld_o  (ent_vld),
        .ent_rd_o   (ent_rd)
    );

    // set is applied after clear so a reissue to the retiring register stays busy
    always_comb begin
        busy_d = busy_q;
        if (ld_acc) busy_d[ld_rd] = 1'b0;
        if (issue_ld && issue_rd != '0) busy_d[issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            we_q   <= 1'b0;
            wb_q   <= '0;
        end else begin
            busy_q <= busy_d;
            we_q   <= we_d;
            wb_q   <= wb_d;
        end
    end

    assign reg_we = we_q;
    assign rd     = wb_q.rd;
    assign rd_val = wb_q.val;

    assign src = {rs2, rs1};

    always_comb begin
        hit = '0;
        for (int s = 0; s < 2; s++) begin
            hit[s] = busy_q[src[s]] || (we_q && wb_q.rd == src[s]);
            for (int e = 0; e < QDEPTH; e++)
                hit[s] = hit[s] || (ent_vld[e] && ent_rd[e] == src[s]);
            hit[s] = hit[s] && src[s] != '0;
        end
    end

    assign stall = rst_n && |hit;
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: directed stimulus with a queue-based reference model checked every cycle.
module tb_writeback_unit;
    localparam int QD = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, alu_ready, ld_valid, ld_ready, issue_ld, stall, reg_we;
    logic [4:0]  alu_rd, ld_rd, issue_rd, rs1, rs2, rd;
    logic [31:0] alu_val, ld_val, rd_val;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] val;
    } ent_t;

    ent_t        mq[$];
    bit          mbusy[32];
    bit          m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_val;
    int          wlog[$];

    always #5 clk = ~clk;

    writeback_unit #(.NREG(32), .QDEPTH(QD)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_val(alu_val),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_val(ld_val),
        .issue_ld(issue_ld), .issue_rd(issue_rd), .rs1(rs1), .rs2(rs2), .stall(stall),
        .reg_we(reg_we), .rd(rd), .rd_val(rd_val)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        foreach (mbusy[k]) mbusy[k] = 0;
        m_we = 0; m_rd = 0; m_val = 0;
    endfunction

    // one clock of the writeback rules: priority pick, ALU enqueue, scoreboard update
    function automatic void model_step();
        ent_t e = '{5'd0, 32'd0};
        bit have = 0;
        bit ld_acc = 0;
        bit byp = 0;
        if (mq.size() == QD) begin
            e = mq.pop_front(); have = 1;
        end else begin
            if (ld_valid) begin e = '{ld_rd, ld_val}; have = 1; ld_acc = 1; end
            else if (mq.size() != 0) begin e = mq.pop_front(); have = 1; end
            else if (alu_valid) begin e = '{alu_rd, alu_val}; have = 1; byp = 1; end
            if (alu_valid && !byp) mq.push_back('{alu_rd, alu_val});
        end
        if (ld_acc) mbusy[ld_rd] = 0;
        if (issue_ld && issue_rd != 0) mbusy[issue_rd] = 1;
        m_we = have && e.rd != 0;
        m_rd = e.rd;
        m_val = e.val;
    endfunction

    function automatic bit hazard(input logic [4:0] r);
        if (r == 0) return 0;
        if (mbusy[r] || (m_we && m_rd == r)) return 1;
        foreach (mq[k]) if (mq[k].rd == r) return 1;
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        chk("alu_ready", {31'd0, alu_ready}, {31'd0, rst_n && mq.size() < QD});
        chk("ld_ready", {31'd0, ld_ready}, {31'd0, rst_n && mq.size() < QD});
        chk("stall", {31'd0, stall}, {31'd0, rst_n && (hazard(rs1) || hazard(rs2))});
        chk("reg_we", {31'd0, reg_we}, {31'd0, m_we});
        if (!rst_n) begin
            chk("rd_rst", {27'd0, rd}, 32'd0);
            chk("rd_val_rst", rd_val, 32'd0);
        end else if (m_we) begin
            chk("rd", {27'd0, rd}, {27'd0, m_rd});
            chk("rd_val", rd_val, m_val);
        end
        if (reg_we) wlog.push_back(int'(rd));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ai, li;
        bit a_acc, l_acc, saw_full;
        rst_n = 0;
        alu_valid = 0; alu_rd = 0; alu_val = 0;
        ld_valid = 0; ld_rd = 0; ld_val = 0;
        issue_ld = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("lit_rst_we", {31'd0, reg_we}, 32'd0);
        chk("lit_rst_ready", {30'd0, alu_ready, ld_ready}, 32'd0);
        @(negedge clk) rst_n = 1;
        tick();
        chk("lit_ready_after_rst", {30'd0, alu_ready, ld_ready}, 32'd3);

        // lone ALU result bypasses the queue
        alu_valid = 1; alu_rd = 5; alu_val = 32'hDEADBEEF;
        tick();
        alu_valid = 0;
        chk("lit_byp_we", {31'd0, reg_we}, 32'd1);
        chk("lit_byp_rd", {27'd0, rd}, 32'd5);
        chk("lit_byp_val", rd_val, 32'hDEADBEEF);
        chk("lit_byp_qempty", {31'd0, alu_ready}, 32'd1);
        tick();
        chk("lit_byp_once", {31'd0, reg_we}, 32'd0);

        // load beats a simultaneous ALU result; queued ALU retires in order
        wlog.delete();
        alu_valid = 1; alu_rd = 3; alu_val = 32'h11;
        ld_valid = 1; ld_rd = 4; ld_val = 32'h22;
        tick();
        chk("lit_ord_r4", {27'd0, rd}, 32'd4);
        chk("lit_ord_v22", rd_val, 32'h22);
        alu_rd = 6; alu_val = 32'h33; ld_valid = 0;
        tick();
        alu_valid = 0;
        chk("lit_ord_r3", {27'd0, rd}, 32'd3);
        chk("lit_ord_v11", rd_val, 32'h11);
        tick();
        chk("lit_ord_r6", {27'd0, rd}, 32'd6);
        chk("lit_ord_v33", rd_val, 32'h33);
        tick();
        chk("lit_ord_count", wlog.size(), 32'd3);
        if (wlog.size() == 3) chk("lit_ord_seq", {wlog[0][7:0], wlog[1][7:0], wlog[2][7:0]}, 32'h040306);

        // sustained loads against a filling ALU queue
        wlog.delete();
        ai = 0; li = 0; saw_full = 0;
        rs2 = 12;
        for (int c = 0; c < 20 && (ai < 3 || li < 4); c++) begin
            alu_valid = ai < 3; alu_rd = 5'(10 + ai); alu_val = 32'hA0 + ai;
            ld_valid = li < 4; ld_rd = 5'(13 + li); ld_val = 32'hC0 + li;
            if (!alu_ready && !ld_ready) saw_full = 1;
            a_acc = alu_valid && alu_ready;
            l_acc = ld_valid && ld_ready;
            tick();
            ai += int'(a_acc); li += int'(l_acc);
        end
        alu_valid = 0; ld_valid = 0;
        chk("lit_fill_done", {30'd0, ai < 3, li < 4}, 32'd0);
        chk("lit_fill_sawfull", {31'd0, saw_full}, 32'd1);
        repeat (3) tick();
        rs2 = 0;
        chk("lit_fill_count", wlog.size(), 32'd7);
        if (wlog.size() == 7) begin
            chk("lit_fill_seq_a", {wlog[0][7:0], wlog[1][7:0], wlog[2][7:0], wlog[3][7:0]}, 32'h0D0E0A0F);
            chk("lit_fill_seq_b", {8'd0, wlog[4][7:0], wlog[5][7:0], wlog[6][7:0]}, 32'h000B100C);
        end

        // load-use hazard on r7
        issue_ld = 1; issue_rd = 7; rs1 = 7;
        tick();
        issue_ld = 0;
        chk("lit_haz_set", {31'd0, stall}, 32'd1);
        tick();
        chk("lit_haz_hold", {31'd0, stall}, 32'd1);
        ld_valid = 1; ld_rd = 7; ld_val = 32'h55;
        tick();
        ld_valid = 0;
        chk("lit_haz_wb_we", {31'd0, reg_we}, 32'd1);
        chk("lit_haz_wb_rd", {27'd0, rd}, 32'd7);
        chk("lit_haz_wb_stall", {31'd0, stall}, 32'd1);
        tick();
        chk("lit_haz_clear", {31'd0, stall}, 32'd0);

        // rd=0 results are consumed silently
        wlog.delete();
        rs1 = 0;
        alu_valid = 1; alu_rd = 0; alu_val = 32'h77;
        ld_valid = 1; ld_rd = 0; ld_val = 32'h88;
        issue_ld = 1; issue_rd = 0;
        tick();
        alu_valid = 0; ld_valid = 0; issue_ld = 0;
        chk("lit_r0_stall", {31'd0, stall}, 32'd0);
        repeat (2) tick();
        chk("lit_r0_nowrite", wlog.size(), 32'd0);
        chk("lit_r0_empty", {31'd0, alu_ready}, 32'd1);

        // reset with a full queue and an outstanding load
        rs1 = 9;
        issue_ld = 1; issue_rd = 9;
        ld_valid = 1; ld_rd = 20; ld_val = 32'h20;
        alu_valid = 1; alu_rd = 21; alu_val = 32'h21;
        tick();
        issue_ld = 0; ld_rd = 22; ld_val = 32'h22; alu_rd = 23; alu_val = 32'h23;
        tick();
        alu_valid = 0; ld_valid = 0;
        chk("lit_mid_full", {30'd0, alu_ready, ld_ready}, 32'd0);
        chk("lit_mid_stall", {31'd0, stall}, 32'd1);
        #1 rst_n = 0;
        #1;
        chk("lit_mid_we", {31'd0, reg_we}, 32'd0);
        chk("lit_mid_rd", {27'd0, rd}, 32'd0);
        chk("lit_mid_val", rd_val, 32'd0);
        chk("lit_mid_stall0", {31'd0, stall}, 32'd0);
        wlog.delete();
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (4) tick();
        chk("lit_post_nowrite", wlog.size(), 32'd0);
        chk("lit_post_stall", {31'd0, stall}, 32'd0);
        chk("lit_post_ready", {30'd0, alu_ready, ld_ready}, 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
